// File: rtl/bist_pkg.sv
// Shared constants for the BIST address/compare datapath.
package bist_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned AD_WIDTH_DEF   = 4;
  localparam int unsigned RD_LAT_MAX     = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bist_addr_counter.sv
// Up/down address counter with clear/load-ones and direction-aware terminal-count decode.
module bist_addr_counter
  import bist_pkg::*;
#(
  parameter int unsigned AD_WIDTH = AD_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reset,
  input  logic                preset,
  input  logic                en,
  input  logic                up_down,
  output logic [AD_WIDTH-1:0] count,
  output logic                carry
);

  logic [AD_WIDTH-1:0] r_count;
  logic [AD_WIDTH-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (reset) begin
      w_count_d = '0;
    end else if (preset) begin
      w_count_d = '1;
    end else if (en) begin
      if (up_down == DIR_UP) begin
        w_count_d = r_count + AD_WIDTH'(1);
      end else begin
        w_count_d = r_count - AD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  // Terminal count follows the requested direction, independent of en.
  assign carry = (up_down == DIR_UP) ? (r_count == '1) : (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/bist_datapath.sv
// BIST datapath: address counter, memory strobes, read-compare pipeline and first-fail capture.
module bist_datapath
  import bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned AD_WIDTH   = AD_WIDTH_DEF,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reset,
  input  logic                  preset,
  input  logic                  en,
  input  logic                  up_down,
  output logic                  carry,
  input  logic                  read,
  input  logic                  write,
  input  logic                  data,
  output logic                  is_equal,
  output logic                  cmp_valid,
  output logic [AD_WIDTH-1:0]   mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fail_seen,
  output logic [AD_WIDTH-1:0]   fail_addr
);

  logic [AD_WIDTH-1:0]   w_count;
  logic [DATA_WIDTH-1:0] w_pattern;
  logic                  w_mem_re;

  bist_addr_counter #(
    .AD_WIDTH(AD_WIDTH)
  ) u_addr_counter (
    .clk    (clk),
    .rst    (rst),
    .reset  (reset),
    .preset (preset),
    .en     (en),
    .up_down(up_down),
    .count  (w_count),
    .carry  (carry)
  );

  assign w_pattern = {DATA_WIDTH{data}};
  // Write has priority; a read issued alongside it is dropped entirely.
  assign w_mem_re  = read & ~write;

  assign mem_addr  = w_count;
  assign mem_wdata = w_pattern;
  assign mem_we    = write;
  assign mem_re    = w_mem_re;

  logic [RD_LAT-1:0]                 r_vld;
  logic [RD_LAT-1:0][DATA_WIDTH-1:0] r_exp;
  logic [RD_LAT-1:0][AD_WIDTH-1:0]   r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= '0;
      r_exp  <= '0;
      r_addr <= '0;
    end else begin
      // A read issued in the start cycle survives the flush.
      r_vld[0] <= w_mem_re;
      if (w_mem_re) begin
        r_exp[0]  <= w_pattern;
        r_addr[0] <= w_count;
      end
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_vld[i]  <= r_vld[i-1] & ~start;
        r_exp[i]  <= r_exp[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  logic                w_last_vld;
  logic                w_match;
  logic [AD_WIDTH-1:0] w_last_addr;

  assign w_last_vld  = r_vld[RD_LAT-1] & ~start;
  assign w_match     = (mem_rdata == r_exp[RD_LAT-1]);
  assign w_last_addr = r_addr[RD_LAT-1];

  logic                r_cmp_valid;
  logic                r_is_equal;
  logic                r_fail_seen;
  logic [AD_WIDTH-1:0] r_fail_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmp_valid <= 1'b0;
      r_is_equal  <= 1'b1;
    end else begin
      r_cmp_valid <= w_last_vld;
      if (w_last_vld) begin
        r_is_equal <= w_match;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fail_seen <= 1'b0;
      r_fail_addr <= '0;
    end else if (start) begin
      r_fail_seen <= 1'b0;
      r_fail_addr <= '0;
    end else if (w_last_vld && !w_match && !r_fail_seen) begin
      r_fail_seen <= 1'b1;
      r_fail_addr <= w_last_addr;
    end
  end

  assign cmp_valid = r_cmp_valid;
  assign is_equal  = r_is_equal;
  assign fail_seen = r_fail_seen;
  assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_bist_datapath.sv
// Scoreboard bench for bist_datapath: bench-owned memory, directed plan steps, then random traffic.
module tb_bist_datapath;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst, start, reset, preset, en, up_down, read, write, data;
  logic       carry, is_equal, cmp_valid, mem_we, mem_re, fail_seen;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  bist_datapath #(
    .DATA_WIDTH(8),
    .AD_WIDTH  (4),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reset    (reset),
    .preset   (preset),
    .en       (en),
    .up_down  (up_down),
    .carry    (carry),
    .read     (read),
    .write    (write),
    .data     (data),
    .is_equal (is_equal),
    .cmp_valid(cmp_valid),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fail_seen(fail_seen),
    .fail_addr(fail_addr)
  );

  // Memory under test; inj lets the bench plant arbitrary words.
  logic [7:0] mem   [16];
  logic [7:0] rpipe [RD_LAT];
  logic       inj;
  logic [3:0] inj_addr;
  logic [7:0] inj_val;

  always @(posedge clk) begin
    if (inj) mem[inj_addr] <= inj_val;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= mem_re ? mem[mem_addr] : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [3:0] addr;
    bit       eq;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         st_cyc = -1;
  logic [3:0] addr_m;
  bit         iseq_m = 1'b1;
  bit         fail_m = 1'b0;
  logic [3:0] fail_addr_m = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: retires compares in issue order and tracks sticky fail state.
  initial begin
    exp_t e;
    exp_t keep[$];
    bit   due;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        iseq_m      = 1'b1;
        fail_m      = 1'b0;
        fail_addr_m = 4'h0;
      end
      due = (q.size() != 0) && (q[0].cyc == cyc);
      chk("cmp_valid", cmp_valid, due);
      if (due) begin
        e      = q.pop_front();
        iseq_m = e.eq;
        if (!e.eq && !fail_m) begin
          fail_m      = 1'b1;
          fail_addr_m = e.addr;
        end
      end
      chk("is_equal", is_equal, iseq_m);
      chk("fail_seen", fail_seen, fail_m);
      chk("fail_addr", fail_addr, fail_addr_m);
      // start in this cycle kills every read whose compare had not yet completed.
      if (st_cyc == cyc) begin
        keep.delete();
        foreach (q[i]) if (q[i].cyc > cyc + RD_LAT) keep.push_back(q[i]);
        q           = keep;
        fail_m      = 1'b0;
        fail_addr_m = 4'h0;
      end
    end
  end

  // One cycle: entered at posedge+1 with inputs set, returns at next posedge+1.
  task automatic tick();
    exp_t e;
    if (read && !write) begin
      e.cyc  = cyc + RD_LAT + 1;
      e.addr = addr_m;
      e.eq   = (mem[addr_m] == {8{data}});
      q.push_back(e);
    end
    if (start) st_cyc = cyc;
    @(negedge clk);
    chk("mem_addr", mem_addr, addr_m);
    chk("carry", carry, up_down ? (addr_m == 4'hF) : (addr_m == 4'h0));
    chk("mem_re", mem_re, read & ~write);
    chk("mem_we", mem_we, write);
    chk("mem_wdata", mem_wdata, {8{data}});
    @(posedge clk);
    if (reset) addr_m = 4'h0;
    else if (preset) addr_m = 4'hF;
    else if (en) addr_m = up_down ? addr_m + 4'd1 : addr_m - 4'd1;
    #1;
    reset = 0; preset = 0; start = 0; read = 0; write = 0; inj = 0;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    addr_m = 4'h0;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic goto(input int a);
    reset = 1; tick();
    en = 1; up_down = 1;
    repeat (a) tick();
    en = 0;
  endtask

  task automatic plant(input logic [3:0] a, input logic [7:0] v);
    inj = 1; inj_addr = a; inj_val = v; tick();
  endtask

  function automatic logic [7:0] pick_word();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int r;
    rst = 0; start = 0; reset = 0; preset = 0; en = 0; up_down = 0;
    read = 0; write = 0; data = 0; inj = 0; inj_addr = 0; inj_val = 0;
    addr_m = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    for (int a = 0; a < 16; a++) plant(4'(a), pick_word());

    // Up count through the wrap.
    reset = 1; tick();
    en = 1; up_down = 1;
    repeat (17) tick();
    // Down count from all-ones, then flip direction at 0.
    en = 0; preset = 1; tick();
    en = 1; up_down = 0;
    repeat (15) tick();
    en = 0; up_down = 1; tick();

    // Matching read at 3.
    start = 1; tick();
    plant(4'h3, 8'hFF);
    goto(3); read = 1; data = 1; tick();
    repeat (3) tick();
    // First mismatch at 5, later one at 9, then start clears.
    plant(4'h5, 8'h04); plant(4'h9, 8'h00);
    goto(5); read = 1; data = 0; tick();
    repeat (3) tick();
    goto(9); read = 1; data = 1; tick();
    repeat (3) tick();
    start = 1; tick();
    repeat (2) tick();

    // Back-to-back reads 0..3 with a miss only at 2.
    plant(4'h0, 8'hFF); plant(4'h1, 8'hFF); plant(4'h2, 8'h00); plant(4'h3, 8'hFF);
    goto(0);
    en = 1; up_down = 1;
    for (int i = 0; i < 4; i++) begin read = 1; data = 1; tick(); end
    en = 0;
    repeat (3) tick();

    // Reset with a read in flight, then simultaneous read+write.
    goto(6); read = 1; data = 1; tick();
    do_reset();
    repeat (2) tick();
    read = 1; write = 1; data = 1; tick();
    repeat (3) tick();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      r       = $urandom_range(0, 99);
      reset   = (r < 3);
      preset  = (r >= 3) && (r < 6);
      start   = (r >= 6) && (r < 10);
      en      = 1'($urandom_range(0, 1));
      up_down = 1'($urandom_range(0, 1));
      data    = 1'($urandom_range(0, 1));
      read    = ($urandom_range(0, 99) < 60);
      write   = ($urandom_range(0, 99) < 20);
      inj     = !write && ($urandom_range(0, 9) == 0);
      inj_addr = 4'($urandom);
      inj_val  = pick_word();
      tick();
    end
    repeat (RD_LAT + 3) tick();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bist_datapath.md
Name: bist_datapath

Overview:
Address/compare datapath driven by the BIST memory FSM (mem_FSM) and consumed by it. It holds the up/down address counter and returns the terminal-count `carry` to the FSM. It issues read/write strobes and a replicated data pattern to the memory under test. It pipelines read data against the expected pattern and returns `is_equal` to the FSM, and it captures the address of the first failing read.

Parameters:
- DATA_WIDTH, 8: memory word width.
- AD_WIDTH, 4: address width; counter range 0 .. 2^AD_WIDTH-1.
- RD_LAT, 1: memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  sync pulse; clears fail capture and flushes the compare pipeline.
- reset  in  1  sync counter clear to 0.
- preset  in  1  sync counter load to all-ones.
- en  in  1  counter step enable.
- up_down  in  1  1 = count up, 0 = count down.
- carry  out  1  terminal count reached in the current direction.
- read  in  1  issue a read at the current address.
- write  in  1  issue a write at the current address.
- data  in  1  pattern bit; replicated across the word.
- is_equal  out  1  result of the last completed compare.
- cmp_valid  out  1  1-cycle pulse; a compare completed.
- mem_addr  out  AD_WIDTH  address to the memory.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_wdata  out  DATA_WIDTH  write data to the memory.
- mem_rdata  in  DATA_WIDTH  read data from the memory, valid RD_LAT cycles after mem_re.
- fail_seen  out  1  sticky: at least one mismatch since rst or start.
- fail_addr  out  AD_WIDTH  address of the first mismatch.

Behaviour:
- Reset values (rst low, asynchronous): counter=0, is_equal=1, cmp_valid=0, fail_seen=0, fail_addr=0, pipeline valid bits=0. In-flight reads are discarded.
- Counter priority per cycle: reset > preset > en.
  - en with up_down=1: +1 modulo 2^AD_WIDTH (15 wraps to 0).
  - en with up_down=0: -1 modulo 2^AD_WIDTH (0 wraps to 15).
  - Without en, reset or preset: hold.
- carry is combinational: up_down ? (counter==all-ones) : (counter==0). It does not depend on en.
- mem_addr = counter. mem_wdata = {DATA_WIDTH{data}}. mem_we = write. mem_re = read & ~write (write wins when both are asserted; that read is dropped and not compared).
- Read pipeline:
  - On a cycle with mem_re, capture expected={DATA_WIDTH{data}}, addr=counter and valid=1 into stage 0.
  - The entry shifts one stage per cycle for RD_LAT stages.
  - At the end of cycle t+RD_LAT, compare mem_rdata against the expected value and register the result.
  - In cycle t+RD_LAT+1: cmp_valid=1 and is_equal=(match). is_equal then holds until the next compare.
  - Back-to-back reads every cycle are supported. Throughput is 1 compare/cycle and results come back in issue order.
- Fail capture: on a registered mismatch with fail_seen=0, set fail_seen=1 and fail_addr=entry addr. Later mismatches do not overwrite it.
- start:
  - Clears fail_seen and fail_addr and zeroes all pipeline valid bits, so no cmp_valid follows from earlier reads.
  - Leaves the counter and is_equal unchanged.
  - A read in the same cycle as start is kept.
- reset or preset while reads are in flight: the pipeline is unaffected; in-flight compares complete using their captured addresses.
- A mismatch registered in the same cycle as start: start wins, so fail_seen=0.

Decomposition:
- Shared package bist_pkg:
  - Default DATA_WIDTH/AD_WIDTH.
  - RD_LAT_MAX=4.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
- Sub-module bist_addr_counter: reset/preset/en/up_down counter plus carry decode.
- Compare pipeline and fail capture stay in bist_datapath.

Test Plan:
1. AD_WIDTH=4, reset pulse, then en=1, up_down=1 for 16 cycles -> mem_addr steps 0..15 with carry=1 only at 15. The 17th step gives addr 0 with carry=0.
2. preset, then en=1, up_down=0 -> addr 15..0 with carry=1 only at 0. Switching up_down to 1 at addr 0 gives carry=0 immediately.
3. RD_LAT=1, read at addr 3 with data=1, memory returns 0xFF -> cmp_valid pulse at t+2, is_equal=1, fail_seen=0.
4. Read addr 5 with data=0, memory returns 0x04 -> is_equal=0 at t+2, fail_seen=1, fail_addr=5. A later mismatch at addr 9 leaves fail_addr=5. start then clears fail_seen to 0.
5. Back-to-back reads of addr 0..3 with a mismatch only at addr 2 -> 4 consecutive cmp_valid pulses, is_equal=1,1,0,1, fail_addr=2.
6. rst driven low one cycle after a read, and read+write asserted together -> no cmp_valid after rst and every output at its reset value. The simultaneous read+write gives mem_we=1, mem_re=0 and no compare.
